// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO; a byte shows on rd_data one cycle after its stop sample.
// The serial line cannot be stalled: a byte arriving at a full FIFO with no pop is dropped and overrun is flagged.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RxD,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]       BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]       HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            armed_q, armed_d;
  logic            rx_s1, rx_s2;
  logic [1:0]      flush_q;
  logic            push, ferr_evt;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop, ovr_evt;

  // flush_q masks the reset value still sitting in the synchronizer, so a
  // line that is low at release is not mistaken for a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      flush_q <= 2'b00;
    end else begin
      rx_s1   <= RxD;
      rx_s2   <= rx_s1;
      flush_q <= {flush_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  // armed_q records that the line has been seen high since the last frame,
  // which turns "line low while armed" into a genuine 1->0 transition
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    armed_d  = armed_q;
    push     = 1'b0;
    ferr_evt = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (flush_q[1] && rx_s2) armed_d = 1'b1;
        if (armed_q && !rx_s2) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          state_d = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {rx_s2, shift_q[7:1]};
          bit_d   = bit_q + 3'(1);
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d    = '0;
          state_d  = IDLE;
          armed_d  = rx_s2;
          push     = rx_s2;
          ferr_evt = !rx_s2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign count   = count_q;
  assign do_pop  = rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovr_evt = push && full && !do_pop;
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // a new error in the same cycle as clr_err wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_evt)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (ferr_evt)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at CLKS_PER_BIT=16, DEPTH_LOG2=3.
// Frames start one tick after a clock edge, so the stop sample lands 155 edges later.
module tb_uart_rx_buffered;

  logic       clk = 1'b0;
  logic       rst, RxD, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, overrun, frame_err;
  logic [3:0] count;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_rx_buffered #(.CLKS_PER_BIT(16), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .RxD(RxD), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .frame_err(frame_err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // caller is aligned one tick after an edge; returns at the same alignment
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RxD = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; RxD = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    #12;
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (count !== 4'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk); #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_before_push: empty got %b want 1", empty); end
        @(posedge clk); #1;
        checks++; if (empty !== 1'b0)   begin errors++; $display("FAIL single_after_push: empty got %b want 0", empty); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rd_data); end
        checks++; if (count !== 4'd1)   begin errors++; $display("FAIL single_count: got %0d want 1", count); end
      end
    join
    pop();
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL single_pop_empty: got %b want 1", empty); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL single_pop_data: got %h want 00", rd_data); end
    pop();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL empty_pop_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_pop_empty: got %b want 1", empty); end
  endtask

  task automatic test_glitch();
    RxD = 1'b0;
    repeat (3) @(posedge clk); #1;
    RxD = 1'b1;
    repeat (40) @(posedge clk); #1;
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL glitch_no_push: empty got %b want 1", empty); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_no_flag: frame_err got %b want 0", frame_err); end
    send_frame(8'hC3, 1'b1);
    checks++; if (count !== 4'd1)    begin errors++; $display("FAIL glitch_next_count: got %0d want 1", count); end
    checks++; if (rd_data !== 8'hC3) begin errors++; $display("FAIL glitch_next_data: got %h want c3", rd_data); end
    pop();
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
    checks++; if (count !== 4'd8)   begin errors++; $display("FAIL fill_count: got %0d want 8", count); end
    checks++; if (full !== 1'b1)    begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_no_overrun: got %b want 0", overrun); end
    send_frame(8'h08, 1'b1);
    checks++; if (count !== 4'd8)   begin errors++; $display("FAIL overrun_count: got %0d want 8", count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL fill_order_%0d: got %h want %h", i, rd_data, 8'(i)); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained: empty got %b want 1", empty); end
    send_frame(8'h77, 1'b1);
    checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL wrap_data: got %h want 77", rd_data); end
    pop();
    pulse_clr();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_framing();
    fork
      send_frame(8'h3C, 1'b0);
      begin
        repeat (154) @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
      end
    join
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_priority: got %b want 1", frame_err); end
    checks++; if (count !== 4'd0)     begin errors++; $display("FAIL frame_no_push: count got %0d want 0", count); end
    RxD = 1'b1;
    repeat (32) @(posedge clk); #1;
    send_frame(8'h3C, 1'b1);
    checks++; if (rd_data !== 8'h3C)  begin errors++; $display("FAIL frame_good_data: got %h want 3c", rd_data); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_sticky: got %b want 1", frame_err); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clear: got %b want 0", frame_err); end
    pop();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
    fork
      send_frame(8'h18, 1'b1);
      begin
        repeat (154) @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        checks++; if (count !== 4'd8)   begin errors++; $display("FAIL full_pushpop_count: got %0d want 8", count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pushpop_overrun: got %b want 0", overrun); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL full_pushpop_head: got %h want 11", rd_data); end
      end
    join
    for (int i = 1; i < 8; i++) begin
      checks++; if (rd_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_order_%0d: got %h want %h", i, rd_data, 8'h10 + 8'(i)); end
      pop();
    end
    checks++; if (rd_data !== 8'h18) begin errors++; $display("FAIL b2b_last: got %h want 18", rd_data); end
    fork
      send_frame(8'h19, 1'b1);
      begin
        repeat (154) @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        checks++; if (count !== 4'd1)    begin errors++; $display("FAIL one_pushpop_count: got %0d want 1", count); end
        checks++; if (rd_data !== 8'h19) begin errors++; $display("FAIL one_pushpop_data: got %h want 19", rd_data); end
      end
    join
    pop();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drained: empty got %b want 1", empty); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h42, 1'b1);
    send_frame(8'h99, 1'b0);
    RxD = 1'b1;
    repeat (32) @(posedge clk); #1;
    RxD = 1'b0;
    repeat (16) @(posedge clk); #1;
    RxD = 1'b1;
    repeat (64) @(posedge clk); #1;
    RxD = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #2;
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL midreset_empty: got %b want 1", empty); end
    checks++; if (count !== 4'd0)     begin errors++; $display("FAIL midreset_count: got %0d want 0", count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midreset_frame_err: got %b want 0", frame_err); end
    checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL midreset_rd_data: got %h want 00", rd_data); end
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (32) @(posedge clk); #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL low_at_release: empty got %b want 1", empty); end
    RxD = 1'b1;
    repeat (32) @(posedge clk); #1;
    send_frame(8'h5A, 1'b1);
    checks++; if (count !== 4'd1)     begin errors++; $display("FAIL after_reset_count: got %0d want 1", count); end
    checks++; if (rd_data !== 8'h5A)  begin errors++; $display("FAIL after_reset_data: got %h want 5a", rd_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL after_reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL after_reset_overrun: got %b want 0", overrun); end
    pop();
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_fill_overrun();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
